step_motor_sequencer: RTL and testbench

//  Drives one bipolar stepper channel (AX/AY/BX/BY/AE/BE) that the pin matrix routes to PIO26 pins.

---
 rtl/step_motor_sequencer.sv | 149 ++++++++++++++
 tb/tb_step_motor_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_sequencer.sv
// Bipolar stepper channel sequencer: one move command in, phase table out, absolute position tracked.
// Build option HALF_STEP_EN: defined -> index advances by 1 per step, undefined -> full-step by 2.
//
// state | meaning
// IDLE  | waiting for a command; coils held at current phase if hold_en, else off
// RUN   | issuing steps at the latched period until count exhausted or abort

module step_motor_sequencer #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 24,
  parameter int POS_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             hold_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic             AX,
  output logic             AY,
  output logic             BX,
  output logic             BY,
  output logic             AE,
  output logic             BE
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef HALF_STEP_EN
  localparam logic [2:0] IDX_STEP = 3'd1;
`else
  localparam logic [2:0] IDX_STEP = 3'd2;
`endif

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] load_per;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [5:0]       coil_q, coil_d;

  // {AX, AY, BX, BY, AE, BE}
  function automatic logic [5:0] phase_drive(input logic [2:0] idx);
    logic [5:0] drv;
    case (idx)
      3'd0:    drv = 6'b10_10_11;
      3'd1:    drv = 6'b00_10_01;
      3'd2:    drv = 6'b01_10_11;
      3'd3:    drv = 6'b01_00_10;
      3'd4:    drv = 6'b01_01_11;
      3'd5:    drv = 6'b00_01_01;
      3'd6:    drv = 6'b10_01_11;
      default: drv = 6'b10_00_10;
    endcase
    return drv;
  endfunction

  assign load_per = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_d     = div_q;
    per_d     = per_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d = cmd_dir;
          rem_d = cmd_steps;
          per_d = load_per;
          div_d = load_per;
          if (cmd_steps != '0) state_d = RUN;
          else                 done_d  = 1'b1;
        end
      end
      RUN: begin
        // abort takes priority over a step that would land on the same edge
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (div_q == '0) begin
          div_d = per_q;
          idx_d = dir_q ? idx_q + IDX_STEP : idx_q - IDX_STEP;
          pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
    endcase
    coil_d = (state_d == RUN || hold_en) ? phase_drive(idx_d) : 6'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      per_q     <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      coil_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      per_q     <= per_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      coil_q    <= coil_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign position  = pos_q;
  assign {AX, AY, BX, BY, AE, BE} = coil_q;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Directed self-checking bench for step_motor_sequencer; a second instance with a 4-bit
// position counter exercises position wrap-around cheaply.

module tb_step_motor_sequencer;
  localparam int CNT_W = 16;
  localparam int DIV_W = 24;
  localparam int POS_W = 32;
`ifdef HALF_STEP_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 2;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [DIV_W-1:0] cmd_period = '0;
  logic             abort = 1'b0;
  logic             hold_en = 1'b0;
  logic             cmd_ready, busy, done, aborted;
  logic [POS_W-1:0] position;
  logic             AX, AY, BX, BY, AE, BE;
  logic             w_cmd_ready, w_busy, w_done, w_aborted;
  logic [3:0]       w_position;
  logic             w_AX, w_AY, w_BX, w_BY, w_AE, w_BE;
  logic [5:0]       coil, w_coil;
  logic [3:0]       status, w_status;

  int tests_run = 0;
  int tests_failed = 0;
  int m_idx = 0;
  int m_pos = 0;

  always #5 clock = ~clock;

  step_motor_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) u_dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .hold_en(hold_en), .busy(busy), .done(done), .aborted(aborted), .position(position),
    .AX(AX), .AY(AY), .BX(BX), .BY(BY), .AE(AE), .BE(BE));

  step_motor_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(4)) u_wrap (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .hold_en(hold_en), .busy(w_busy), .done(w_done), .aborted(w_aborted), .position(w_position),
    .AX(w_AX), .AY(w_AY), .BX(w_BX), .BY(w_BY), .AE(w_AE), .BE(w_BE));

  assign coil     = {AX, AY, BX, BY, AE, BE};
  assign w_coil   = {w_AX, w_AY, w_BX, w_BY, w_AE, w_BE};
  assign status   = {busy, done, aborted, cmd_ready};
  assign w_status = {w_busy, w_done, w_aborted, w_cmd_ready};

  // coil drive {AX,AY,BX,BY,AE,BE} for each phase index
  function automatic logic [5:0] phase_bits(input int i);
    case (i)
      0: return 6'b101011;
      1: return 6'b001001;
      2: return 6'b011011;
      3: return 6'b010010;
      4: return 6'b010111;
      5: return 6'b000101;
      6: return 6'b100111;
      default: return 6'b100010;
    endcase
  endfunction

  function automatic int nxt_idx(input int i, input logic dir);
    return dir ? (i + STEP) % 8 : (i + 8 - STEP) % 8;
  endfunction

  // present a command at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic dir, input int steps, input int period);
    cmd_dir    = dir;
    cmd_steps  = steps[CNT_W-1:0];
    cmd_period = period[DIV_W-1:0];
    cmd_valid  = 1'b1;
    @(negedge clock);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hold_en = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tests_run++;
    if (coil !== 6'b0) begin tests_failed++; $display("FAIL reset_coil got %b want %b", coil, 6'b0); end
    tests_run++;
    if (status !== 4'b0001) begin tests_failed++; $display("FAIL reset_status got %b want %b", status, 4'b0001); end
    tests_run++;
    if (position !== '0) begin tests_failed++; $display("FAIL reset_position got %0d want 0", position); end
    @(negedge clock);
    tests_run++;
    if (coil !== 6'b0) begin tests_failed++; $display("FAIL reset_idle_coil got %b want %b", coil, 6'b0); end
  endtask

  task automatic test_full_step();
    int taken = 0;
    logic [3:0] es;
    hold_en = 1'b1;
    @(negedge clock);
    tests_run++;
    if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL hold_coil got %b want %b", coil, phase_bits(m_idx)); end
    send_cmd(1'b1, 4, 3);
    tests_run++;
    if (status !== 4'b1000) begin tests_failed++; $display("FAIL fwd_accept_status got %b want %b", status, 4'b1000); end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k % 3 == 0 && taken < 4) begin m_idx = nxt_idx(m_idx, 1'b1); m_pos++; taken++; end
      es = {1'(taken < 4), 1'(k == 12), 1'b0, 1'(taken >= 4)};
      tests_run++;
      if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL fwd_coil k=%0d got %b want %b", k, coil, phase_bits(m_idx)); end
      tests_run++;
      if (status !== es) begin tests_failed++; $display("FAIL fwd_status k=%0d got %b want %b", k, status, es); end
      tests_run++;
      if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL fwd_position k=%0d got %0d want %0d", k, $signed(position), m_pos); end
    end
  endtask

  task automatic test_fast_reverse();
    int taken = 0;
    int start_pos;
    logic [3:0] es;
    start_pos = m_pos;
    send_cmd(1'b0, 3, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (taken < 3) begin m_idx = nxt_idx(m_idx, 1'b0); m_pos--; taken++; end
      es = {1'(taken < 3), 1'(k == 3), 1'b0, 1'(taken >= 3)};
      tests_run++;
      if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL rev_coil k=%0d got %b want %b", k, coil, phase_bits(m_idx)); end
      tests_run++;
      if (status !== es) begin tests_failed++; $display("FAIL rev_status k=%0d got %b want %b", k, status, es); end
      tests_run++;
      if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL rev_position k=%0d got %0d want %0d", k, $signed(position), m_pos); end
    end
    tests_run++;
    if ($signed(position) - start_pos !== -3) begin tests_failed++; $display("FAIL rev_delta got %0d want -3", $signed(position) - start_pos); end
  endtask

  task automatic test_hold_idle();
    hold_en = 1'b0;
    @(negedge clock);
    tests_run++;
    if (coil !== 6'b0) begin tests_failed++; $display("FAIL unhold_coil got %b want %b", coil, 6'b0); end
    hold_en = 1'b1;
    @(negedge clock);
    tests_run++;
    if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL rehold_coil got %b want %b", coil, phase_bits(m_idx)); end
  endtask

  task automatic test_abort();
    int taken = 0;
    logic [3:0] es;
    send_cmd(1'b1, 10, 5);
    for (int k = 1; k <= 16; k++) begin
      if (k == 12) abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      if (k % 5 == 0 && k < 12) begin m_idx = nxt_idx(m_idx, 1'b1); m_pos++; taken++; end
      es = {1'(k < 12), 1'(k == 12), 1'(k == 12), 1'(k >= 12)};
      tests_run++;
      if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL abort_coil k=%0d got %b want %b", k, coil, phase_bits(m_idx)); end
      tests_run++;
      if (status !== es) begin tests_failed++; $display("FAIL abort_status k=%0d got %b want %b", k, status, es); end
      tests_run++;
      if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL abort_position k=%0d got %0d want %0d", k, $signed(position), m_pos); end
    end
    tests_run++;
    if (taken !== 2) begin tests_failed++; $display("FAIL abort_steps_model got %0d want 2", taken); end
    // abort on the same edge the divider expires: no step
    send_cmd(1'b0, 5, 2);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      es = {1'(k < 2), 1'(k == 2), 1'(k == 2), 1'(k >= 2)};
      tests_run++;
      if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL abort_wins_coil k=%0d got %b want %b", k, coil, phase_bits(m_idx)); end
      tests_run++;
      if (status !== es) begin tests_failed++; $display("FAIL abort_wins_status k=%0d got %b want %b", k, status, es); end
      tests_run++;
      if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL abort_wins_position k=%0d got %0d want %0d", k, $signed(position), m_pos); end
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    tests_run++;
    if (status !== 4'b0001) begin tests_failed++; $display("FAIL abort_idle_status got %b want %b", status, 4'b0001); end
  endtask

  task automatic test_zero_and_busy_cmd();
    logic [3:0] es;
    send_cmd(1'b1, 0, 4);
    tests_run++;
    if (status !== 4'b0101) begin tests_failed++; $display("FAIL zero_done_status got %b want %b", status, 4'b0101); end
    tests_run++;
    if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL zero_coil got %b want %b", coil, phase_bits(m_idx)); end
    tests_run++;
    if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL zero_position got %0d want %0d", $signed(position), m_pos); end
    @(negedge clock);
    tests_run++;
    if (status !== 4'b0001) begin tests_failed++; $display("FAIL zero_after_status got %b want %b", status, 4'b0001); end
    // cmd_valid held with a different command while busy must be ignored
    send_cmd(1'b1, 2, 4);
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b0;
    cmd_steps  = CNT_W'(7);
    cmd_period = DIV_W'(1);
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) cmd_valid = 1'b0;
      @(negedge clock);
      if (k == 4 || k == 8) begin m_idx = nxt_idx(m_idx, 1'b1); m_pos++; end
      es = {1'(k < 8), 1'(k == 8), 1'b0, 1'(k >= 8)};
      tests_run++;
      if (status !== es) begin tests_failed++; $display("FAIL busy_cmd_status k=%0d got %b want %b", k, status, es); end
      tests_run++;
      if (position !== POS_W'(m_pos)) begin tests_failed++; $display("FAIL busy_cmd_position k=%0d got %0d want %0d", k, $signed(position), m_pos); end
    end
    tests_run++;
    if (coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL busy_cmd_coil got %b want %b", coil, phase_bits(m_idx)); end
  endtask

  task automatic test_reset_mid_move();
    send_cmd(1'b1, 5, 3);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    tests_run++;
    if (coil !== 6'b0) begin tests_failed++; $display("FAIL midrst_coil got %b want %b", coil, 6'b0); end
    tests_run++;
    if (status !== 4'b0001) begin tests_failed++; $display("FAIL midrst_status got %b want %b", status, 4'b0001); end
    tests_run++;
    if (position !== '0) begin tests_failed++; $display("FAIL midrst_position got %0d want 0", $signed(position)); end
    @(negedge clock);
    reset_n = 1'b1;
    m_idx = 0;
    m_pos = 0;
    @(negedge clock);
    tests_run++;
    if (status !== 4'b0001) begin tests_failed++; $display("FAIL midrst_nodone got %b want %b", status, 4'b0001); end
    tests_run++;
    if (coil !== phase_bits(0)) begin tests_failed++; $display("FAIL midrst_hold_coil got %b want %b", coil, phase_bits(0)); end
  endtask

  task automatic test_position_wrap();
    send_cmd(1'b1, 7, 1);
    repeat (7) @(negedge clock);
    for (int s = 0; s < 7; s++) m_idx = nxt_idx(m_idx, 1'b1);
    tests_run++;
    if (w_position !== 4'd7) begin tests_failed++; $display("FAIL wrap_max got %b want %b", w_position, 4'd7); end
    tests_run++;
    if (position !== POS_W'(7)) begin tests_failed++; $display("FAIL wrap_main7 got %0d want 7", $signed(position)); end
    send_cmd(1'b1, 1, 1);
    @(negedge clock);
    m_idx = nxt_idx(m_idx, 1'b1);
    tests_run++;
    if (w_position !== 4'b1000) begin tests_failed++; $display("FAIL wrap_to_min got %b want %b", w_position, 4'b1000); end
    tests_run++;
    if (w_status !== 4'b0101) begin tests_failed++; $display("FAIL wrap_status got %b want %b", w_status, 4'b0101); end
    tests_run++;
    if (w_coil !== phase_bits(m_idx)) begin tests_failed++; $display("FAIL wrap_coil got %b want %b", w_coil, phase_bits(m_idx)); end
    send_cmd(1'b0, 1, 1);
    @(negedge clock);
    tests_run++;
    if (w_position !== 4'd7) begin tests_failed++; $display("FAIL wrap_back got %b want %b", w_position, 4'd7); end
    tests_run++;
    if (position !== POS_W'(7)) begin tests_failed++; $display("FAIL wrap_main_back got %0d want 7", $signed(position)); end
  endtask

  initial begin
    test_reset();
    test_full_step();
    test_fast_reverse();
    test_hold_idle();
    test_abort();
    test_zero_and_busy_cmd();
    test_reset_mid_move();
    test_position_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
